// File: rtl/dcache_responder_pkg.sv
// Shared types for the data-cache responder: address split, frame layout and
// the frame-array write operations.
package dcache_responder_pkg;

  typedef logic [31:0] word_t;

  localparam int DCACHE_SETS = 16;
  localparam int DIDX_W      = $clog2(DCACHE_SETS);
  localparam int DTAG_W      = 32 - 3 - DIDX_W;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    word_t [1:0]       data;
  } dcache_frame_t;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_WRITE,
    FRAME_INSTALL,
    FRAME_CLEAN
  } frame_op_e;

  function automatic word_t blk_addr(input logic [DTAG_W-1:0] tag,
                                     input logic [DIDX_W-1:0] idx,
                                     input logic              word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Datapath and memory-control signals of the data cache, bundled as one port.
interface dcache_responder_if;
  import dcache_responder_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  halt;
  logic  dhit;
  word_t dmemload;
  logic  flushed;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dwait;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

endinterface

// File: rtl/dcache_responder_frame_array.sv
// Direct-mapped frame storage: one lookup port (tag compare + victim view)
// and one write port for word update, block install and dirty clear.
module dcache_responder_frame_array
  import dcache_responder_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DIDX_W-1:0] lk_idx,
  input  logic [DTAG_W-1:0] lk_tag,
  output logic              hit,
  output dcache_frame_t     frame,
  input  frame_op_e         op,
  input  logic              wr_blkoff,
  input  word_t             wr_word,
  input  word_t             fill_word
);

  logic [DCACHE_SETS-1:0] valid_q;
  logic [DCACHE_SETS-1:0] dirty_q;
  logic [DTAG_W-1:0]      tag_mem  [DCACHE_SETS];
  word_t [1:0]            data_mem [DCACHE_SETS];

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    frame       = '0;
    frame.valid = valid_q[lk_idx];
    frame.dirty = dirty_q[lk_idx];
    frame.tag   = tag_mem[lk_idx];
    frame.data  = data_mem[lk_idx];
    hit         = frame.valid && (frame.tag == lk_tag);
  end

  // NOTE: registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (op)
        FRAME_WRITE:   dirty_q[lk_idx] <= 1'b1;
        FRAME_INSTALL: begin
          valid_q[lk_idx] <= 1'b1;
          dirty_q[lk_idx] <= 1'b0;
        end
        FRAME_CLEAN:   dirty_q[lk_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: tag/data storage has no reset; the reset valid bits make its contents irrelevant.
  always_ff @(posedge CLK) begin
    case (op)
      FRAME_WRITE:   data_mem[lk_idx][wr_blkoff] <= wr_word;
      FRAME_INSTALL: begin
        tag_mem[lk_idx]  <= lk_tag;
        data_mem[lk_idx] <= {wr_word, fill_word};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache: zero-latency hits, two-word block
// refill/victim write-back over dREN/dWEN/dwait, and a halt-time flush.
module dcache_responder
  import dcache_responder_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  dcache_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DIDX_W-1:0] cnt_q, cnt_d;
  dcachef_t          miss_q, miss_d;
  word_t             fill_q, fill_d;

  dcachef_t          req;
  logic [DIDX_W-1:0] lk_idx;
  logic [DTAG_W-1:0] lk_tag;
  logic              hit;
  dcache_frame_t     frame;
  frame_op_e         op;
  logic              wr_blkoff;
  word_t             wr_word;
  logic              wsel;

  assign req  = dcachef_t'(bus.dmemaddr);
  assign wsel = (state_q == WB1) || (state_q == FWB1);

  // Refill/write-back work on the latched miss frame; the flush walks the counter.
  always_comb begin
    lk_idx = req.idx;
    lk_tag = req.tag;
    if (state_q inside {WB0, WB1, LD0, LD1}) begin
      lk_idx = miss_q.idx;
      lk_tag = miss_q.tag;
    end else if (state_q inside {FLUSH, FWB0, FWB1}) begin
      lk_idx = cnt_q;
      lk_tag = miss_q.tag;
    end
  end

  dcache_responder_frame_array u_frames (
    .CLK       (CLK),
    .nRST      (nRST),
    .lk_idx    (lk_idx),
    .lk_tag    (lk_tag),
    .hit       (hit),
    .frame     (frame),
    .op        (op),
    .wr_blkoff (wr_blkoff),
    .wr_word   (wr_word),
    .fill_word (fill_q)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      miss_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_d        = miss_q;
    fill_d        = fill_q;
    op            = FRAME_NONE;
    wr_blkoff     = req.blkoff;
    wr_word       = bus.dmemstore;
    bus.dhit      = 1'b0;
    bus.dmemload  = '0;
    bus.flushed   = 1'b0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;

    case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d = FLUSH;
        end else if (bus.dmemREN || bus.dmemWEN) begin
          if (hit) begin
            bus.dhit = 1'b1;
            if (bus.dmemREN) bus.dmemload = frame.data[req.blkoff];
            else             op = FRAME_WRITE;
          end else begin
            miss_d  = req;
            state_d = frame.dirty ? WB0 : LD0;
          end
        end
      end

      WB0, WB1, FWB0, FWB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = blk_addr(frame.tag, lk_idx, wsel);
        bus.dstore = frame.data[wsel];
        if (!bus.dwait) begin
          case (state_q)
            WB0:     state_d = WB1;
            WB1:     state_d = LD0;
            FWB0:    state_d = FWB1;
            default: begin
              op      = FRAME_CLEAN;
              state_d = FLUSH;
            end
          endcase
        end
      end

      LD0: begin
        bus.dREN  = 1'b1;
        bus.daddr = blk_addr(miss_q.tag, miss_q.idx, 1'b0);
        if (!bus.dwait) begin
          fill_d  = bus.dload;
          state_d = LD1;
        end
      end

      LD1: begin
        bus.dREN  = 1'b1;
        bus.daddr = blk_addr(miss_q.tag, miss_q.idx, 1'b1);
        wr_word   = bus.dload;
        if (!bus.dwait) begin
          op      = FRAME_INSTALL;
          state_d = IDLE;
        end
      end

      FLUSH: begin
        if (frame.dirty)                              state_d = FWB0;
        else if (cnt_q == DIDX_W'(DCACHE_SETS - 1))   state_d = DONE;
        else                                          cnt_d   = cnt_q + 1'b1;
      end

      DONE: bus.flushed = 1'b1;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder against a fixed-latency word memory model.
module tb_dcache_responder;
  import dcache_responder_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  dcache_responder_if bus ();

  dcache_responder dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // ---------------- memory model: 2 busy cycles, then completes ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         wr_log[$];
  logic [31:0] rd_log[$];
  bit   [31:0] mem     [128];
  bit          written [128];
  int          mcnt;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h100)      return 32'h0000_AAAA;
    else if (a == 32'h104) return 32'h0000_BBBB;
    else                   return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.dwait = !((bus.dREN || bus.dWEN) && mcnt == 2);
  assign bus.dload = written[bus.daddr[8:2]] ? mem[bus.daddr[8:2]] : init_val(bus.daddr);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mcnt <= 0;
    end else if (bus.dREN || bus.dWEN) begin
      if (mcnt == 2) begin
        mcnt <= 0;
        if (bus.dWEN) begin
          mem[bus.daddr[8:2]]     <= bus.dstore;
          written[bus.daddr[8:2]] <= 1'b1;
          wr_log.push_back('{addr: bus.daddr, data: bus.dstore});
        end else begin
          rd_log.push_back(bus.daddr);
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int n, input logic [31:0] a, input logic [31:0] d);
    if (n < wr_log.size()) begin
      check({tag, "_addr"}, wr_log[n].addr, a);
      check({tag, "_data"}, wr_log[n].data, d);
    end else begin
      check({tag, "_missing"}, 32'(wr_log.size()), 32'(n + 1));
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_dhit"},     32'(bus.dhit),    32'd0);
    check({pfx, "_dREN"},     32'(bus.dREN),    32'd0);
    check({pfx, "_dWEN"},     32'(bus.dWEN),    32'd0);
    check({pfx, "_flushed"},  32'(bus.flushed), 32'd0);
    check({pfx, "_daddr"},    bus.daddr,        32'd0);
    check({pfx, "_dstore"},   bus.dstore,       32'd0);
    check({pfx, "_dmemload"}, bus.dmemload,     32'd0);
  endtask

  task automatic do_reset(input string pfx);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_reset_outputs(pfx);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // Holds a request until dhit (sampled at negedge); cyc counts cycles incl. the hit cycle.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] data, output int cyc);
    bit hit = 1'b0;
    data = '0;
    cyc  = 0;
    bus.dmemaddr  = addr;
    bus.dmemstore = wdata;
    bus.dmemREN   = !wr;
    bus.dmemWEN   = wr;
    while (!hit && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (bus.dhit === 1'b1) begin
        hit  = 1'b1;
        data = bus.dmemload;
      end
    end
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    if (!hit) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_flushed(input string tag);
    int n = 0;
    while (bus.flushed !== 1'b1 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(bus.flushed), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rdata;
  int          cyc;
  int          rd0;
  int          wr0;
  bit          found;

  initial begin
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.halt      = 1'b0;

    do_reset("rst0");

    // Cold read: LD0, LD1 (2 busy cycles each), hit one cycle later.
    rd0 = rd_log.size();
    access(1'b0, 32'h100, '0, rdata, cyc);
    check("cold_rd_data", rdata, 32'h0000_AAAA);
    check("cold_rd_cycles", 32'(cyc), 32'd8);
    check("cold_rd_nreads", 32'(rd_log.size() - rd0), 32'd2);
    check("cold_rd_addr0", rd_log[rd0], 32'h100);
    check("cold_rd_addr1", rd_log[rd0 + 1], 32'h104);
    check("cold_rd_nwrites", 32'(wr_log.size()), 32'd0);

    // Write hit, then read-back hit with no memory traffic.
    rd0 = rd_log.size();
    access(1'b1, 32'h104, 32'h1234, rdata, cyc);
    check("wr_hit_cycles", 32'(cyc), 32'd1);
    access(1'b0, 32'h104, '0, rdata, cyc);
    check("rd_after_wr_data", rdata, 32'h1234);
    check("rd_after_wr_cycles", 32'(cyc), 32'd1);
    check("rd_after_wr_nreads", 32'(rd_log.size() - rd0), 32'd0);

    // Conflict miss: dirty victim written back, then refill.
    rd0 = rd_log.size();
    access(1'b0, 32'h180, '0, rdata, cyc);
    check("conflict_data", rdata, 32'hC0DE_0180);
    check("conflict_cycles", 32'(cyc), 32'd14);
    check("conflict_nwrites", 32'(wr_log.size()), 32'd2);
    check_wr("conflict_wb0", 0, 32'h100, 32'h0000_AAAA);
    check_wr("conflict_wb1", 1, 32'h104, 32'h1234);
    check("conflict_nreads", 32'(rd_log.size() - rd0), 32'd2);

    // Make idx 0 and idx 5 dirty.
    access(1'b1, 32'h180, 32'hDEAD, rdata, cyc);
    check("dirty0_cycles", 32'(cyc), 32'd1);
    access(1'b1, 32'h02C, 32'h5A5A, rdata, cyc);
    check("dirty5_cycles", 32'(cyc), 32'd8);

    // halt beats a pending hit request, then the flush writes back exactly 4 words.
    wr0 = wr_log.size();
    rd0 = rd_log.size();
    bus.halt     = 1'b1;
    bus.dmemaddr = 32'h180;
    bus.dmemREN  = 1'b1;
    @(negedge CLK);
    check("halt_prio_dhit", 32'(bus.dhit), 32'd0);
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    wait_flushed("flush_a_done");
    check("flush_a_nwrites", 32'(wr_log.size() - wr0), 32'd4);
    check_wr("flush_a_0", wr0,     32'h180, 32'hDEAD);
    check_wr("flush_a_1", wr0 + 1, 32'h184, 32'hC0DE_0184);
    check_wr("flush_a_2", wr0 + 2, 32'h028, 32'hC0DE_0028);
    check_wr("flush_a_3", wr0 + 3, 32'h02C, 32'h5A5A);

    // After flush: sticky flushed, requests ignored, no memory traffic.
    bus.dmemaddr = 32'h100;
    bus.dmemREN  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("done_dhit", 32'(bus.dhit), 32'd0);
      check("done_flushed", 32'(bus.flushed), 32'd1);
    end
    bus.dmemREN = 1'b0;
    check("done_nreads", 32'(rd_log.size() - rd0), 32'd0);

    // halt raised during LD0: load finishes and installs, then the flush runs.
    bus.halt = 1'b0;
    do_reset("rst1");
    access(1'b1, 32'h028, 32'h7777, rdata, cyc);
    check("b_dirty5_cycles", 32'(cyc), 32'd8);
    wr0 = wr_log.size();
    rd0 = rd_log.size();
    bus.dmemaddr = 32'h010;
    bus.dmemREN  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (bus.dREN === 1'b1) found = 1'b1;
    end
    check("b_ld0_seen", 32'(found), 32'd1);
    bus.halt    = 1'b1;
    bus.dmemREN = 1'b0;
    wait_flushed("flush_b_done");
    check("flush_b_nreads", 32'(rd_log.size() - rd0), 32'd2);
    check("flush_b_rd0", rd_log[rd0], 32'h010);
    check("flush_b_rd1", rd_log[rd0 + 1], 32'h014);
    check("flush_b_nwrites", 32'(wr_log.size() - wr0), 32'd2);
    check_wr("flush_b_0", wr0,     32'h028, 32'h7777);
    check_wr("flush_b_1", wr0 + 1, 32'h02C, 32'h5A5A);

    // Reset pulsed while WB1 is stalled on dwait.
    bus.halt = 1'b0;
    do_reset("rst2");
    access(1'b0, 32'h100, '0, rdata, cyc);
    check("c_rd_data", rdata, 32'h0000_AAAA);
    access(1'b1, 32'h100, 32'h9999, rdata, cyc);
    check("c_wr_cycles", 32'(cyc), 32'd1);
    wr0 = wr_log.size();
    bus.dmemaddr = 32'h180;
    bus.dmemREN  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLK);
      if (bus.dWEN === 1'b1 && bus.daddr == 32'h104 && bus.dwait === 1'b1) found = 1'b1;
    end
    check("c_wb1_seen", 32'(found), 32'd1);
    check("c_wb1_dstore", bus.dstore, 32'h1234);
    nRST = 1'b0;
    #1;
    check("c_rst_dWEN", 32'(bus.dWEN), 32'd0);
    check("c_rst_dREN", 32'(bus.dREN), 32'd0);
    bus.dmemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    check("c_nwrites", 32'(wr_log.size() - wr0), 32'd1);
    check_wr("c_wb0", wr0, 32'h100, 32'h9999);
    rd0 = rd_log.size();
    access(1'b0, 32'h100, '0, rdata, cyc);
    check("c_after_rst_data", rdata, 32'h9999);
    check("c_after_rst_cycles", 32'(cyc), 32'd8);
    check("c_after_rst_nreads", 32'(rd_log.size() - rd0), 32'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
